// File: rtl/io_pkg.sv
// Shared definitions for the board I/O blocks: column strobe patterns,
// key code width, keypad FSM states and the per-frame scan result.
package io_pkg;

  localparam int KEY_W = 4;

  localparam logic [3:0] COL0 = 4'b1110;
  localparam logic [3:0] COL1 = 4'b1101;
  localparam logic [3:0] COL2 = 4'b1011;
  localparam logic [3:0] COL3 = 4'b0111;

  typedef enum logic {
    S_UP   = 1'b0,
    S_DOWN = 1'b1
  } state_t;

  // The key field is kept at zero when hit=0 so "none" compares equal
  // across frames as a full 5-bit value.
  typedef struct packed {
    logic             hit;
    logic [KEY_W-1:0] key;
  } frame_t;

  localparam frame_t FRAME_NONE = '{hit: 1'b0, key: '0};

  // Position of the lowest active-low row; only meaningful when r != 4'hF.
  function automatic logic [1:0] low_zero(input logic [3:0] r);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!r[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_scan_timer.sv
// Column dwell divider for the keypad scan: emits one tick per dwell and
// rotates the one-cold column strobe on that tick.
module key_scan_timer
  import io_pkg::*;
#(
  parameter int SCAN_DIV = 14'h3000
) (
  input  logic       clk,
  input  logic       rst,
  output logic       tick,
  output logic [3:0] col,
  output logic [1:0] ci
);

  logic [13:0] cnt;

  assign tick = (cnt == 14'(SCAN_DIV));

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 14'd1;
      col <= COL0;
    end else if (tick) begin
      cnt <= 14'd1;
      col <= {col[2:0], col[3]};
    end else begin
      cnt <= cnt + 14'd1;
    end
  end

  always_comb begin
    ci = 2'd0;
    case (col)
      COL1:    ci = 2'd1;
      COL2:    ci = 2'd2;
      COL3:    ci = 2'd3;
      default: ci = 2'd0;
    endcase
  end

endmodule

// File: rtl/io_key.sv
// 4x4 matrix keypad front end: row synchronizer, per-frame capture,
// frame-level debounce, press/rollover FSM and read/clear handshake.
module io_key
  import io_pkg::*;
#(
  parameter int SCAN_DIV = 14'h3000,
  parameter int DEB_CNT  = 3
) (
  input  logic             clk,
  input  logic             rst,
  output logic [3:0]       col,
  input  logic [3:0]       row,
  output logic [KEY_W-1:0] code,
  output logic             vld,
  input  logic             rd,
  output logic             ovf,
  output logic             pressed
);

  logic       tick;
  logic [1:0] ci;
  logic [3:0] row_m, row_s;

  key_scan_timer #(.SCAN_DIV(SCAN_DIV)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .tick (tick),
    .col  (col),
    .ci   (ci)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_m <= 4'hF;
      row_s <= 4'hF;
    end else begin
      row_m <= row;
      row_s <= row_m;
    end
  end

  // Frame capture: the first hit of the frame sticks (lowest ci, then ri).
  frame_t acc, smp, frm;
  logic   frame_end;

  assign frame_end = tick && (ci == 2'd3);

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    smp = FRAME_NONE;
    if (row_s != 4'hF) begin
      smp.hit = 1'b1;
      smp.key = {ci, low_zero(row_s)};
    end
    frm = acc.hit ? acc : smp;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            acc <= FRAME_NONE;
    else if (frame_end) acc <= FRAME_NONE;
    else if (tick)      acc <= frm;
  end

  // Debounce across whole frames.
  frame_t     cand, cand_n;
  logic [2:0] stb, stb_n;
  logic       accept;

  always_comb begin
    cand_n = cand;
    stb_n  = stb;
    if (frm == cand) begin
      if (stb != 3'(DEB_CNT)) stb_n = stb + 3'd1;
    end else begin
      cand_n = frm;
      stb_n  = 3'd1;
    end
  end

  assign accept = frame_end && (stb_n == 3'(DEB_CNT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand <= FRAME_NONE;
      stb  <= 3'd0;
    end else if (frame_end) begin
      cand <= cand_n;
      stb  <= stb_n;
    end
  end

  // Press FSM: a new key from either state is an event; holding is not.
  state_t           state, state_n;
  logic [KEY_W-1:0] dkey, dkey_n;
  logic             ev, ev_n;

  always_comb begin
    state_n = state;
    dkey_n  = dkey;
    ev_n    = 1'b0;
    if (accept) begin
      case (state)
        S_UP: begin
          if (cand_n.hit) begin
            state_n = S_DOWN;
            dkey_n  = cand_n.key;
            ev_n    = 1'b1;
          end
        end
        S_DOWN: begin
          if (!cand_n.hit) begin
            state_n = S_UP;
          end else if (cand_n.key != dkey) begin
            dkey_n = cand_n.key;
            ev_n   = 1'b1;
          end
        end
        default: state_n = S_UP;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_UP;
      dkey  <= '0;
      ev    <= 1'b0;
    end else begin
      state <= state_n;
      dkey  <= dkey_n;
      ev    <= ev_n;
    end
  end

  assign pressed = (state == S_DOWN);

  // A new event outranks a read in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code <= '0;
      vld  <= 1'b0;
      ovf  <= 1'b0;
    end else if (ev) begin
      code <= dkey;
      vld  <= 1'b1;
      if (vld && !rd) ovf <= 1'b1;
    end else if (rd && vld) begin
      vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_io_key.sv
// Directed bench for io_key with SCAN_DIV=4, DEB_CNT=3 (16-cycle frames);
// a keypad model drives row from col and the set of held keys.
module tb_io_key;

  localparam int FR = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] col;
  logic [3:0] row;
  logic [3:0] code;
  logic       vld;
  logic       rd = 1'b0;
  logic       ovf;
  logic       pressed;

  logic [15:0] keys = 16'h0000;

  int n_vec = 0;
  int n_err = 0;
  int n_ev  = 0;
  logic vld_q = 1'b0;

  io_key #(.SCAN_DIV(4), .DEB_CNT(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .col     (col),
    .row     (row),
    .code    (code),
    .vld     (vld),
    .rd      (rd),
    .ovf     (ovf),
    .pressed (pressed)
  );

  always #5 clk = ~clk;

  // Key k sits at column k/4, row k%4; a held key pulls its row low
  // while its column is strobed.
  always_comb begin
    logic [3:0] sel;
    row = 4'hF;
    for (int k = 0; k < 16; k++) begin
      sel = ~(4'b0001 << (k >> 2));
      if (keys[k] && col == sel) row[k % 4] = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (vld && !vld_q) n_ev++;
    vld_q = vld;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_vld(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (vld) break;
    end
    check(tag, {31'd0, vld}, 32'd1);
  endtask

  task automatic wait_code(input string tag, input logic [3:0] exp, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (code == exp) break;
    end
    check(tag, {28'd0, code}, {28'd0, exp});
  endtask

  task automatic read_pulse();
    @(negedge clk);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic idle_frames(input int n);
    repeat (n * FR) @(negedge clk);
  endtask

  logic [3:0] col_seq [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
  int ev0;

  initial begin
    // 1. Asynchronous reset mid-scan, then column rotation.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_col", {28'd0, col}, 32'hE);
    check("rst_code", {28'd0, code}, 32'h0);
    check("rst_vld", {31'd0, vld}, 32'd0);
    check("rst_pressed", {31'd0, pressed}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("col_rot%0d", i), {28'd0, col}, {28'd0, col_seq[i]});
      repeat (4) @(negedge clk);
    end

    // 2. Clean press of key 6, read, release.
    ev0 = n_ev;
    keys = 16'h0040;
    wait_vld("press6_vld", 4 * FR + 6);
    check("press6_code", {28'd0, code}, 32'h6);
    check("press6_pressed", {31'd0, pressed}, 32'd1);
    read_pulse();
    check("read_clr_vld", {31'd0, vld}, 32'd0);
    check("read_code_hold", {28'd0, code}, 32'h6);
    keys = 16'h0000;
    idle_frames(5);
    check("release_pressed", {31'd0, pressed}, 32'd0);
    check("release_no_ev", n_ev, ev0 + 1);

    // 3. Bounce on alternating frames, then steady.
    ev0 = n_ev;
    for (int i = 0; i < 6; i++) begin
      keys = (i % 2 == 0) ? 16'h0040 : 16'h0000;
      repeat (FR) @(negedge clk);
    end
    check("bounce_no_ev", n_ev, ev0);
    check("bounce_vld", {31'd0, vld}, 32'd0);
    keys = 16'h0040;
    wait_vld("bounce_steady_vld", 5 * FR);
    check("bounce_code", {28'd0, code}, 32'h6);
    idle_frames(2);
    check("bounce_one_ev", n_ev, ev0 + 1);
    read_pulse();
    keys = 16'h0000;
    idle_frames(5);

    // 4. Two keys at once, then rollover to the remaining one.
    keys = 16'h0204;
    wait_vld("multi_vld", 5 * FR);
    check("multi_code", {28'd0, code}, 32'h2);
    read_pulse();
    keys = 16'h0200;
    wait_vld("roll_vld", 5 * FR);
    check("roll_code", {28'd0, code}, 32'h9);
    check("roll_pressed", {31'd0, pressed}, 32'd1);
    check("roll_ovf", {31'd0, ovf}, 32'd0);
    read_pulse();
    keys = 16'h0000;
    idle_frames(5);

    // 5. Overflow on an unread event, async reset, then read racing an event.
    keys = 16'h0008;
    wait_vld("ovf_first_vld", 5 * FR);
    check("ovf_first_code", {28'd0, code}, 32'h3);
    keys = 16'h0400;
    wait_code("ovf_second_code", 4'hA, 5 * FR);
    check("ovf_set", {31'd0, ovf}, 32'd1);
    check("ovf_vld", {31'd0, vld}, 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    keys = 16'h0008;
    #1;
    check("rst2_ovf", {31'd0, ovf}, 32'd0);
    check("rst2_vld", {31'd0, vld}, 32'd0);
    check("rst2_code", {28'd0, code}, 32'h0);
    check("rst2_pressed", {31'd0, pressed}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    // Key 3 is seen in frames ending at edges 16/32/48; event lands at edge 49.
    repeat (48) @(posedge clk);
    @(negedge clk);
    check("lat_before", {31'd0, vld}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("lat_vld", {31'd0, vld}, 32'd1);
    check("lat_code", {28'd0, code}, 32'h3);
    keys = 16'h0400;
    // Key A is seen in frames ending at edges 64/80/96; event lands at edge 97.
    repeat (47) @(posedge clk);
    @(negedge clk);
    rd = 1'b1;
    check("race_pre_code", {28'd0, code}, 32'h3);
    @(posedge clk);
    @(negedge clk);
    rd = 1'b0;
    check("race_vld", {31'd0, vld}, 32'd1);
    check("race_code", {28'd0, code}, 32'hA);
    check("race_ovf", {31'd0, ovf}, 32'd0);
    @(negedge clk);
    check("race_vld_hold", {31'd0, vld}, 32'd1);
    read_pulse();
    keys = 16'h0000;
    idle_frames(5);

    // 6. Long hold of key F gives a single event.
    ev0 = n_ev;
    keys = 16'h8000;
    idle_frames(20);
    check("hold_one_ev", n_ev, ev0 + 1);
    check("hold_code", {28'd0, code}, 32'hF);
    check("hold_ovf", {31'd0, ovf}, 32'd0);
    check("hold_pressed", {31'd0, pressed}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/io_key.md
Name: io_key

Overview:
- 4x4 matrix keypad input block; the input-side companion of the 7-segment output driver.
- Drives one-cold active-low column strobes and samples active-low row returns.
- Debounces over whole scan frames and delivers a 4-bit hex key code to the core through a read/clear handshake.
- Sits at the board I/O boundary, alongside the segment display block.

Parameters:
- SCAN_DIV, 14'h3000, clk cycles per column dwell; range 2..16383.
- DEB_CNT, 3, consecutive identical frames required to accept a state change; range 1..7.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- col  out  4  column strobe, one-cold active-low: 1110, 1101, 1011, 0111
- row  in  4  row returns, active-low, asynchronous to clk
- code  out  4  last accepted key code
- vld  out  1  code holds an unread key event
- rd  in  1  read strobe; clears vld
- ovf  out  1  sticky flag: an event arrived while vld=1 and was not being read
- pressed  out  1  debounced "a key is held" level

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values:
  - col=4'b1110; code=4'h0; vld=0; ovf=0; pressed=0.
  - Divider count=1; synchronizer flops=4'hF; frame result=none; candidate=none; stable count=0; FSM=S_UP.
- Synchronizer: row passes through 2 flops (row_s) before any use.
- Divider:
  - cnt runs 1..SCAN_DIV.
  - tick=1 for one cycle when cnt==SCAN_DIV; cnt then returns to 1.
- Column rotation on tick: col <= {col[2:0], col[3]}. Column index ci: 1110=0, 1101=1, 1011=2, 0111=3.
- Sampling:
  - On tick, before rotating, sample row_s for the current column.
  - Row index ri = lowest bit position where row_s is 0.
  - Key index = ci*4 + ri (4'h0..4'hF).
  - Within one frame (ci 0..3), the first hit wins: lowest ci, then lowest ri. Later hits in the same frame are ignored (multi-key resolution).
- Frame end is the tick with ci==3. The frame result F is a 5-bit value {hit, key}; none = {0, x}. Candidate C is compared as the full 5 bits.
  - F==C: stable count increments, saturating at DEB_CNT.
  - F!=C: C<=F, stable count<=1.
  - When stable count reaches DEB_CNT, C is accepted.
- FSM, evaluated only at frame end after acceptance:
  - S_UP:
    - Accepted C=hit k -> S_DOWN, press event with key k.
    - Accepted C=none -> stay.
  - S_DOWN(k):
    - Accepted C=none -> S_UP, no event.
    - Accepted C=hit j, j!=k -> stay S_DOWN(j), press event j (rollover).
    - Accepted C=hit k -> stay, no event (no auto-repeat).
- pressed=1 exactly while the FSM is in S_DOWN.
- Press event, in the cycle after the frame-end tick:
  - code<=key; vld<=1.
  - If vld was 1 and rd=0 in the event cycle, ovf<=1.
- Read handshake:
  - rd=1 with vld=1 clears vld next cycle; code holds its value.
  - rd=1 with vld=0 has no effect.
  - rd and an event in the same cycle: vld stays 1, code takes the new key, ovf unchanged.
- ovf clears only on reset.
- Latency: a clean press is reported within DEB_CNT+1 frames (frame = 4*SCAN_DIV cycles), plus 1 cycle.
- Reset mid-scan: all state returns to reset values immediately; no partial event is emitted.

Decomposition:
- Shared package io_pkg:
  - column patterns COL0..COL3 (4'b1110..4'b0111), shared with the segment selector.
  - KEY_W=4.
  - FSM state encoding S_UP/S_DOWN.
- Sub-module key_scan_timer: divider, tick, column rotation, ci output.
- io_key holds the synchronizer, frame capture, debounce, FSM and handshake.

Test Plan (SCAN_DIV=4, DEB_CNT=3; frame=16 cycles):
1. Reset: assert rst mid-cycle -> col=1110, code=0, vld=0, ovf=0, pressed=0 with no clock edge required. After release, col rotates every 4 cycles: 1110, 1101, 1011, 0111, 1110.
2. Clean press: hold row=1011 whenever col=1101 (key 1*4+2=6) for 5 frames -> vld=1, code=4'h6, pressed=1 within 4 frames. Pulse rd -> vld=0 next cycle, code stays 6. Release -> pressed=0 after 3 none-frames, no event.
3. Bounce: key 6 present on alternating frames for 6 frames, then steady -> no event during the bounce. Exactly one event, code=6, after 3 consecutive steady frames.
4. Multi-key and rollover: hold keys 9 and 2 together -> code=2. Release 2 while keeping 9 -> second event, code=9, pressed stays 1.
5. Overflow and simultaneous read: event 3 then event A with no rd -> ovf=1, code=A. Reset, then event with rd=1 in the same cycle -> vld=1, ovf=0.
6. No auto-repeat: hold key F for 20 frames -> exactly one event.
